// File: rtl/sop_sweep_checker.sv
// Walks an N_IN-input combinational function through all input vectors in ascending order,
// samples its output after a settle interval and compares the observed truth table with a mask.
module sop_sweep_checker #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [(2**N_IN)-1:0]  i_exp_mask,
  input  logic                  i_f_in,
  output logic [N_IN-1:0]       o_vec_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [(2**N_IN)-1:0]  o_tt_out,
  output logic [N_IN:0]         o_fail_count,
  output logic [N_IN-1:0]       o_fail_idx,
  output logic                  o_fail_vld
);

  localparam int unsigned V = 2 ** N_IN;
  localparam logic [7:0]      CntLast = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] LastVec = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StSample} state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_cnt, w_cnt_d;
  logic [V-1:0]    r_mask, w_mask_d;
  logic [N_IN-1:0] r_vec, w_vec_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  logic            r_pass, w_pass_d;
  logic [V-1:0]    r_tt, w_tt_d;
  logic [N_IN:0]   r_fail_count, w_fail_count_d;
  logic [N_IN-1:0] r_fail_idx, w_fail_idx_d;
  logic            r_fail_vld, w_fail_vld_d;
  logic            w_mismatch;

  assign w_mismatch = (i_f_in != r_mask[r_vec]);

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_mask_d       = r_mask;
    w_vec_d        = r_vec;
    w_busy_d       = r_busy;
    w_done_d       = 1'b0;
    w_pass_d       = r_pass;
    w_tt_d         = r_tt;
    w_fail_count_d = r_fail_count;
    w_fail_idx_d   = r_fail_idx;
    w_fail_vld_d   = r_fail_vld;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_mask_d       = i_exp_mask;
          w_tt_d         = '0;
          w_fail_count_d = '0;
          w_fail_idx_d   = '0;
          w_fail_vld_d   = 1'b0;
          w_pass_d       = 1'b0;
          w_busy_d       = 1'b1;
          w_cnt_d        = '0;
          w_state_d      = StSettle;
        end
      end
      StSettle: begin
        w_cnt_d = r_cnt + 8'd1;
        if (r_cnt == CntLast) w_state_d = StSample;
      end
      StSample: begin
        w_tt_d[r_vec] = i_f_in;
        if (w_mismatch) begin
          w_fail_count_d = r_fail_count + (N_IN + 1)'(1);
          if (!r_fail_vld) begin
            w_fail_idx_d = r_vec;
            w_fail_vld_d = 1'b1;
          end
        end
        if (r_vec != LastVec) begin
          w_vec_d   = r_vec + N_IN'(1);
          w_cnt_d   = '0;
          w_state_d = StSettle;
        end else begin
          // Compare against the table including the bit written this cycle.
          w_pass_d  = (w_tt_d == r_mask);
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_vec_d   = '0;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_tt         <= '0;
      r_fail_count <= '0;
      r_fail_idx   <= '0;
      r_fail_vld   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_mask       <= w_mask_d;
      r_vec        <= w_vec_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
      r_tt         <= w_tt_d;
      r_fail_count <= w_fail_count_d;
      r_fail_idx   <= w_fail_idx_d;
      r_fail_vld   <= w_fail_vld_d;
    end
  end

  assign o_vec_out    = r_vec;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_tt_out     = r_tt;
  assign o_fail_count = r_fail_count;
  assign o_fail_idx   = r_fail_idx;
  assign o_fail_vld   = r_fail_vld;

endmodule

// File: tb/tb_sop_sweep_checker.sv
// Directed bench for sop_sweep_checker: a SETTLE=1 instance driven by switchable DUT models and a
// SETTLE=3 instance driven by a correct majority function.
module tb_sop_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [7:0] mask_a, mask_b;
  logic       f_a, f_b;
  logic [1:0] mode;

  logic [2:0] vec_a, vec_b, fi_a, fi_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
  logic [7:0] tt_a, tt_b;
  logic [3:0] fc_a, fc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sop_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_exp_mask(mask_a), .i_f_in(f_a),
    .o_vec_out(vec_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a), .o_tt_out(tt_a),
    .o_fail_count(fc_a), .o_fail_idx(fi_a), .o_fail_vld(fv_a)
  );

  sop_sweep_checker #(.N_IN(3), .SETTLE(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_exp_mask(mask_b), .i_f_in(f_b),
    .o_vec_out(vec_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b), .o_tt_out(tt_b),
    .o_fail_count(fc_b), .o_fail_idx(fi_b), .o_fail_vld(fv_b)
  );

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
  endfunction

  // mode 0: majority, 1: stuck at 0, 2: majority inverted at vector 6
  always_comb begin
    case (mode)
      2'd1:    f_a = 1'b0;
      2'd2:    f_a = maj(vec_a) ^ (vec_a == 3'd6);
      default: f_a = maj(vec_a);
    endcase
  end
  assign f_b = maj(vec_b);

  // One sweep on instance A; the mask input is scrambled right after acceptance.
  task automatic sweep_a(input logic [7:0] mask, output int done_at, output int busy_cnt,
                         output int n_done, output int vec_bad);
    @(posedge clk); #1;
    mask_a  = mask;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a  = 1'b0;
    mask_a   = ~mask;
    done_at  = -1;
    busy_cnt = 0;
    n_done   = 0;
    vec_bad  = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (busy_a) busy_cnt++;
      if (done_a) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      if (k < 16 && vec_a !== 3'(k / 2)) vec_bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mask_a = '0; mask_b = '0; mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({vec_a, busy_a, done_a, pass_a, tt_a, fc_a, fi_a, fv_a} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_a: got %h want 0", {vec_a, busy_a, done_a, pass_a, tt_a, fc_a, fi_a, fv_a});
    end
    n_checks++;
    if ({vec_b, busy_b, done_b, pass_b, tt_b, fc_b, fi_b, fv_b} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_b: got %h want 0", {vec_b, busy_b, done_b, pass_b, tt_b, fc_b, fi_b, fv_b});
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy_a, done_a, vec_a} !== 5'd0) begin
      n_errors++;
      $display("FAIL idle_hold: got %h want 0", {busy_a, done_a, vec_a});
    end
  endtask

  task automatic test_majority;
    int d, b, n, vb;
    mode = 2'd0;
    sweep_a(8'hE8, d, b, n, vb);
    n_checks++; if (d !== 16) begin n_errors++; $display("FAIL maj_done_at: got %0d want 16", d); end
    n_checks++; if (b !== 16) begin n_errors++; $display("FAIL maj_busy: got %0d want 16", b); end
    n_checks++; if (n !== 1) begin n_errors++; $display("FAIL maj_ndone: got %0d want 1", n); end
    n_checks++; if (vb !== 0) begin n_errors++; $display("FAIL maj_vecseq: got %0d bad want 0", vb); end
    n_checks++; if (pass_a !== 1'b1) begin n_errors++; $display("FAIL maj_pass: got %b want 1", pass_a); end
    n_checks++; if (tt_a !== 8'hE8) begin n_errors++; $display("FAIL maj_tt: got %h want e8", tt_a); end
    n_checks++; if (fc_a !== 4'd0) begin n_errors++; $display("FAIL maj_fc: got %0d want 0", fc_a); end
    n_checks++; if (fv_a !== 1'b0) begin n_errors++; $display("FAIL maj_fv: got %b want 0", fv_a); end
    n_checks++; if (fi_a !== 3'd0) begin n_errors++; $display("FAIL maj_fi: got %0d want 0", fi_a); end
  endtask

  task automatic test_stuck0;
    int d, b, n, vb;
    mode = 2'd1;
    sweep_a(8'hE8, d, b, n, vb);
    n_checks++; if (tt_a !== 8'h00) begin n_errors++; $display("FAIL s0_tt: got %h want 00", tt_a); end
    n_checks++; if (fc_a !== 4'd4) begin n_errors++; $display("FAIL s0_fc: got %0d want 4", fc_a); end
    n_checks++; if (fi_a !== 3'd3) begin n_errors++; $display("FAIL s0_fi: got %0d want 3", fi_a); end
    n_checks++; if (fv_a !== 1'b1) begin n_errors++; $display("FAIL s0_fv: got %b want 1", fv_a); end
    n_checks++; if (pass_a !== 1'b0) begin n_errors++; $display("FAIL s0_pass: got %b want 0", pass_a); end
  endtask

  task automatic test_flip6;
    int d, b, n, vb;
    mode = 2'd2;
    sweep_a(8'hE8, d, b, n, vb);
    n_checks++; if (tt_a !== 8'hA8) begin n_errors++; $display("FAIL f6_tt: got %h want a8", tt_a); end
    n_checks++; if (fc_a !== 4'd1) begin n_errors++; $display("FAIL f6_fc: got %0d want 1", fc_a); end
    n_checks++; if (fi_a !== 3'd6) begin n_errors++; $display("FAIL f6_fi: got %0d want 6", fi_a); end
    n_checks++; if (fv_a !== 1'b1) begin n_errors++; $display("FAIL f6_fv: got %b want 1", fv_a); end
    n_checks++; if (pass_a !== 1'b0) begin n_errors++; $display("FAIL f6_pass: got %b want 0", pass_a); end
  endtask

  task automatic test_back_to_back;
    int n_done, d0, d1, vb, t;
    mode = 2'd0;
    n_done = 0; d0 = -1; d1 = -1; vb = 0;
    @(posedge clk); #1;
    mask_a  = 8'hE8;
    start_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_a) begin
        if (n_done == 0) d0 = k;
        else if (n_done == 1) d1 = k;
        n_done++;
      end
      if (k < 16 && vec_a !== 3'(k / 2)) vb++;
      if (k >= 17 && k < 33 && vec_a !== 3'((k - 17) / 2)) vb++;
    end
    start_a = 1'b0;
    n_checks++; if (d0 !== 16) begin n_errors++; $display("FAIL b2b_done0: got %0d want 16", d0); end
    n_checks++; if (d1 !== 33) begin n_errors++; $display("FAIL b2b_done1: got %0d want 33", d1); end
    n_checks++; if (n_done !== 2) begin n_errors++; $display("FAIL b2b_ndone: got %0d want 2", n_done); end
    n_checks++; if (vb !== 0) begin n_errors++; $display("FAIL b2b_vecseq: got %0d bad want 0", vb); end
    t = 0;
    while (busy_a && t < 100) begin @(posedge clk); #1; t++; end
    n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: busy %b want 0", busy_a); end
    n_checks++; if (pass_a !== 1'b1) begin n_errors++; $display("FAIL b2b_pass: got %b want 1", pass_a); end
  endtask

  task automatic test_reset_mid;
    int d, b, n, vb, t;
    mode = 2'd0;
    @(posedge clk); #1;
    mask_a  = 8'hE8;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    t = 0;
    while (vec_a !== 3'd5 && t < 40) begin @(posedge clk); #1; t++; end
    n_checks++; if (vec_a !== 3'd5) begin n_errors++; $display("FAIL rm_reach5: got %0d want 5", vec_a); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if ({vec_a, busy_a, done_a, pass_a, tt_a, fc_a, fi_a, fv_a} !== 22'd0) begin
      n_errors++;
      $display("FAIL rm_clear: got %h want 0", {vec_a, busy_a, done_a, pass_a, tt_a, fc_a, fi_a, fv_a});
    end
    @(posedge clk); #1;
    n_checks++; if ({busy_a, vec_a} !== 4'd0) begin n_errors++; $display("FAIL rm_idle: got %h want 0", {busy_a, vec_a}); end
    sweep_a(8'hE8, d, b, n, vb);
    n_checks++; if (d !== 16) begin n_errors++; $display("FAIL rm_done_at: got %0d want 16", d); end
    n_checks++; if (vb !== 0) begin n_errors++; $display("FAIL rm_vecseq: got %0d bad want 0", vb); end
    n_checks++; if (pass_a !== 1'b1) begin n_errors++; $display("FAIL rm_pass: got %b want 1", pass_a); end
    n_checks++; if (tt_a !== 8'hE8) begin n_errors++; $display("FAIL rm_tt: got %h want e8", tt_a); end
  endtask

  task automatic test_settle3;
    int d, b, n, vb;
    d = -1; b = 0; n = 0; vb = 0;
    @(posedge clk); #1;
    mask_b  = 8'hE8;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (busy_b) b++;
      if (done_b) begin
        n++;
        if (d < 0) d = k;
      end
      if (k < 32 && vec_b !== 3'(k / 4)) vb++;
      if (k == 10) mask_b = 8'h00;
      start_b = (k == 12);
    end
    start_b = 1'b0;
    n_checks++; if (d !== 32) begin n_errors++; $display("FAIL s3_done_at: got %0d want 32", d); end
    n_checks++; if (b !== 32) begin n_errors++; $display("FAIL s3_busy: got %0d want 32", b); end
    n_checks++; if (n !== 1) begin n_errors++; $display("FAIL s3_ndone: got %0d want 1", n); end
    n_checks++; if (vb !== 0) begin n_errors++; $display("FAIL s3_vecseq: got %0d bad want 0", vb); end
    n_checks++; if (pass_b !== 1'b1) begin n_errors++; $display("FAIL s3_pass: got %b want 1", pass_b); end
    n_checks++; if (tt_b !== 8'hE8) begin n_errors++; $display("FAIL s3_tt: got %h want e8", tt_b); end
    n_checks++; if (fc_b !== 4'd0) begin n_errors++; $display("FAIL s3_fc: got %0d want 0", fc_b); end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_stuck0();
    test_flip6();
    test_back_to_back();
    test_reset_mid();
    test_settle3();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
